hazard_detect_unit: RTL and testbench
=====================================

# hazard_detect_unit

Stall/flush controller for the 5-stage RV32 pipeline and the companion of the EX-stage forwarding unit. The forwarding unit resolves what it can with bypass paths. This block detects what forwarding cannot resolve (load-use dependences, taken branches, data-memory wait states) and drives the pipeline-register write enables, bubbles and flushes. It also drives the `stall` input of the forwarding unit. It sits in the ID stage, with a small watchdog FSM and saturating performance counters.

## Interface
- `CNT_W`, 32: width of the performance counters.
- `TO_W`, 8: width of the memory-wait counter.
- `MEM_TIMEOUT`, 64: number of consecutive freeze cycles before the fault. 0 disables the watchdog. Must be < 2^TO_W.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `IF_ID_RegRs1`, `IF_ID_RegRs2` in 5 each: source registers of the instruction in ID.
- `IF_ID_UsesRs1`, `IF_ID_UsesRs2` in 1 each: the ID instruction actually reads that source.
- `ID_EX_MemR` in 1: the instruction in EX is a load.
- `ID_EX_RegRd` in 5: destination register of the EX instruction.
- `EX_BranchTaken` in 1: branch or jump resolved taken in EX.
- `MEM_Req` in 1: data-memory access active in MEM.
- `MEM_Ready` in 1: data memory completes the access this cycle.
- `PC_Write`, `IF_ID_Write`, `ID_EX_Write`, `EX_MEM_Write` out 1 each: pipeline-register enables.
- `IF_ID_Flush`, `ID_EX_Bubble`, `MEM_WB_Bubble` out 1 each: zero the control bits of that register on the next edge.
- `stall` out 1: to the forwarding unit; high on any load-use, freeze or fault cycle.
- `MEM_Err` out 1: sticky watchdog fault.
- `StallCycles` out CNT_W: count of stall cycles.
- `FlushCount` out CNT_W: count of branch flushes.

## Operation
Combinational conditions:
- load_use = `ID_EX_MemR` && rd≠0 && ((rd==rs1 && UsesRs1) || (rd==rs2 && UsesRs2)).
- freeze = `MEM_Req` && !`MEM_Ready`.

Outputs are evaluated in priority order (highest first):
1. **Reset asserted** (`rst_n`=0):
   - All `*_Write`=0.
   - `IF_ID_Flush`=`ID_EX_Bubble`=`MEM_WB_Bubble`=1.
   - `stall`=1.
   - Counters=0, `MEM_Err`=0, FSM=RUN.
2. **ERROR state:**
   - All `*_Write`=0; `MEM_WB_Bubble`=1; `stall`=1.
   - Other flush/bubble outputs 0.
   - Held until reset.
3. **freeze:**
   - All `*_Write`=0; `MEM_WB_Bubble`=1; `stall`=1.
   - `IF_ID_Flush`=`ID_EX_Bubble`=0.
   - A pending `EX_BranchTaken` is ignored here. EX holds, so the branch is presented again after the freeze releases.
4. **EX_BranchTaken:**
   - `IF_ID_Flush`=1, `ID_EX_Bubble`=1.
   - `PC_Write`=`IF_ID_Write`=`ID_EX_Write`=`EX_MEM_Write`=1.
   - `stall`=0.
   - A simultaneous load_use is discarded because the ID instruction is wrong-path.
5. **load_use:**
   - `PC_Write`=`IF_ID_Write`=0; `ID_EX_Bubble`=1.
   - `ID_EX_Write`=`EX_MEM_Write`=1.
   - `stall`=1.
6. **Otherwise:** all enables 1, all flush/bubble 0, `stall`=0.

FSM states:
- **RUN**
  - freeze at an edge → MEM_WAIT, wait_cnt=1.
- **MEM_WAIT**
  - freeze and wait_cnt==`MEM_TIMEOUT` (with `MEM_TIMEOUT`≠0) → ERROR, `MEM_Err`=1.
  - freeze otherwise → wait_cnt+1.
  - !freeze → RUN, wait_cnt=0.
- **ERROR**
  - Terminal until `rst_n` is asserted.

Counters:
- `StallCycles` increments on every edge where `stall`=1 and the FSM is not ERROR.
- `FlushCount` increments on every edge with a rule-4 flush.
- Both saturate at all-ones and never wrap.

## Timing
- All hazard outputs are combinational from current inputs plus state, valid in the same cycle.
- `MEM_Err`, FSM state and counters are registered and update one edge after the event.
- A load-use stall lasts exactly 1 cycle. The bubble clears `ID_EX_MemR` on the next cycle.
- A freeze lasts as long as `MEM_Ready`=0 with `MEM_Req`=1. A single-cycle access (Ready=1 at once) causes no freeze.
- Watchdog: fault if freeze persists for `MEM_TIMEOUT`+1 consecutive cycles. `MEM_Err` is high from the following edge.
- Reset mid-wait: state, wait_cnt, counters and `MEM_Err` clear asynchronously. Normal decoding resumes on the first cycle after deassertion.

## Structure
- Shared pipeline package holds:
  - the FSM state enum {RUN, MEM_WAIT, ERROR};
  - the 5-bit register-index type;
  - the constant for x0.
- One natural sub-module, `sat_counter` (parameterised width, inc, clear), instantiated twice for the two counters.
- Hazard decode and FSM live in the top module.

## Test plan
- **Load-use:** rd=5, `ID_EX_MemR`=1, rs1=5, UsesRs1=1 → one cycle with `PC_Write`=`IF_ID_Write`=0, `ID_EX_Bubble`=1, `stall`=1; `StallCycles` 0→1.
- **False hazards:**
  - rd=0 with rs1=0 → no stall.
  - rs2=5 with UsesRs2=0 → no stall.
- **Branch and load-use together:** both conditions true in the same cycle → `IF_ID_Flush`=`ID_EX_Bubble`=1, `PC_Write`=1, `stall`=0; `FlushCount`=1.
- **Memory wait:** `MEM_Req`=1 with `MEM_Ready` low for 3 cycles → 3 cycles of all enables 0 and `MEM_WB_Bubble`=1, then RUN; `StallCycles`=3.
  - A branch held during the wait flushes in the first cycle after Ready.
- **Watchdog:** `MEM_TIMEOUT`=4, Ready held low → `MEM_Err`=1 after the 5th freeze cycle and stays frozen.
  - Pulse `rst_n` low mid-ERROR → `MEM_Err`=0, FSM in RUN, counters 0.
- **Saturation:** `CNT_W`=4, 20 load-use stalls → `StallCycles` stops at 15.

Source files
------------

// File: rtl/hazard_detect_unit_pkg.sv
// Shared pipeline types for the hazard detection slice.
// Watchdog state, register index type and the x0 constant.
package hazard_detect_unit_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } hz_state_e;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_X0 = 5'd0;

  function automatic logic reads_reg(
    input reg_idx_t rd,
    input reg_idx_t rs,
    input logic     uses
  );
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_detect_unit_if.sv
// Pipeline <-> hazard unit bundle.
// The hazard unit takes the slave side.
interface hazard_detect_unit_if
  import hazard_detect_unit_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  reg_idx_t         IF_ID_RegRs1;
  reg_idx_t         IF_ID_RegRs2;
  logic             IF_ID_UsesRs1;
  logic             IF_ID_UsesRs2;
  logic             ID_EX_MemR;
  reg_idx_t         ID_EX_RegRd;
  logic             EX_BranchTaken;
  logic             MEM_Req;
  logic             MEM_Ready;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             ID_EX_Write;
  logic             EX_MEM_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Bubble;
  logic             MEM_WB_Bubble;
  logic             stall;
  logic             MEM_Err;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output IF_ID_RegRs1, IF_ID_RegRs2,
    output IF_ID_UsesRs1, IF_ID_UsesRs2,
    output ID_EX_MemR, ID_EX_RegRd,
    output EX_BranchTaken,
    output MEM_Req, MEM_Ready,
    input  PC_Write, IF_ID_Write,
    input  ID_EX_Write, EX_MEM_Write,
    input  IF_ID_Flush, ID_EX_Bubble,
    input  MEM_WB_Bubble, stall, MEM_Err,
    input  StallCycles, FlushCount
  );

  modport slave (
    input  IF_ID_RegRs1, IF_ID_RegRs2,
    input  IF_ID_UsesRs1, IF_ID_UsesRs2,
    input  ID_EX_MemR, ID_EX_RegRd,
    input  EX_BranchTaken,
    input  MEM_Req, MEM_Ready,
    output PC_Write, IF_ID_Write,
    output ID_EX_Write, EX_MEM_Write,
    output IF_ID_Flush, ID_EX_Bubble,
    output MEM_WB_Bubble, stall, MEM_Err,
    output StallCycles, FlushCount
  );

endinterface

// File: rtl/hazard_detect_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_detect_unit.sv
// ID-stage stall/flush controller with memory-wait watchdog.
// Hazard outputs are combinational; watchdog and counters are registered.
module hazard_detect_unit
  import hazard_detect_unit_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_detect_unit_if.slave hz
);

  hz_state_e       state;
  logic [TO_W-1:0] wait_cnt;
  logic            mem_err;

  logic load_use;
  logic freeze;
  logic in_err;
  logic sel_rst;
  logic sel_err;
  logic sel_frz;
  logic sel_br;
  logic sel_lu;

  logic pc_w;
  logic ifid_w;
  logic idex_w;
  logic exmem_w;
  logic flush;
  logic bubble;
  logic wb_bubble;
  logic stall;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign load_use = hz.ID_EX_MemR
                 && (hz.ID_EX_RegRd != REG_X0)
                 && (reads_reg(hz.ID_EX_RegRd,
                               hz.IF_ID_RegRs1,
                               hz.IF_ID_UsesRs1)
                  || reads_reg(hz.ID_EX_RegRd,
                               hz.IF_ID_RegRs2,
                               hz.IF_ID_UsesRs2));

  assign freeze = hz.MEM_Req && !hz.MEM_Ready;
  assign in_err = (state == ERROR);

  // Priority flattened into one-hot selects
  assign sel_rst = !rst_n;
  assign sel_err = rst_n && in_err;
  assign sel_frz = rst_n && !in_err && freeze;
  assign sel_br  = rst_n && !in_err && !freeze
                && hz.EX_BranchTaken;
  assign sel_lu  = rst_n && !in_err && !freeze
                && !hz.EX_BranchTaken && load_use;

  always_comb begin
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    idex_w    = 1'b1;
    exmem_w   = 1'b1;
    flush     = 1'b0;
    bubble    = 1'b0;
    wb_bubble = 1'b0;
    stall     = 1'b0;
    unique case (1'b1)
      sel_rst: begin
        {pc_w, ifid_w, idex_w, exmem_w} = '0;
        {flush, bubble, wb_bubble}      = '1;
        stall = 1'b1;
      end
      sel_err, sel_frz: begin
        {pc_w, ifid_w, idex_w, exmem_w} = '0;
        wb_bubble = 1'b1;
        stall     = 1'b1;
      end
      sel_br: begin
        flush  = 1'b1;
        bubble = 1'b1;
      end
      sel_lu: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        bubble = 1'b1;
        stall  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= TO_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!freeze) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if ((MEM_TIMEOUT != 0)
                    && (wait_cnt == TO_W'(MEM_TIMEOUT))) begin
            state   <= ERROR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        ERROR: ;
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall && !in_err),
    .clr   (1'b0),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sel_br),
    .clr   (1'b0),
    .cnt   (flush_cnt)
  );

  assign hz.PC_Write      = pc_w;
  assign hz.IF_ID_Write   = ifid_w;
  assign hz.ID_EX_Write   = idex_w;
  assign hz.EX_MEM_Write  = exmem_w;
  assign hz.IF_ID_Flush   = flush;
  assign hz.ID_EX_Bubble  = bubble;
  assign hz.MEM_WB_Bubble = wb_bubble;
  assign hz.stall         = stall;
  assign hz.MEM_Err       = mem_err;
  assign hz.StallCycles   = stall_cnt;
  assign hz.FlushCount    = flush_cnt;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit: directed scenarios plus random
// traffic checked every cycle against a rule-level model.
module tb_hazard_detect_unit;
  import hazard_detect_unit_pkg::*;

  localparam int CW   = 4;
  localparam int TMO  = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_detect_unit_if #(.CNT_W(CW)) hz ();

  hazard_detect_unit #(
    .CNT_W       (CW),
    .TO_W        (8),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.IF_ID_RegRs1   = 5'd0;
    hz.IF_ID_RegRs2   = 5'd0;
    hz.IF_ID_UsesRs1  = 1'b0;
    hz.IF_ID_UsesRs2  = 1'b0;
    hz.ID_EX_MemR     = 1'b0;
    hz.ID_EX_RegRd    = 5'd0;
    hz.EX_BranchTaken = 1'b0;
    hz.MEM_Req        = 1'b0;
    hz.MEM_Ready      = 1'b0;
  endtask

  task automatic set_lu();
    hz.ID_EX_MemR    = 1'b1;
    hz.ID_EX_RegRd   = 5'd5;
    hz.IF_ID_RegRs1  = 5'd5;
    hz.IF_ID_UsesRs1 = 1'b1;
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Rule-level model: freeze run length, sticky fault, saturating tallies
  int m_run = 0;
  int m_sc  = 0;
  int m_fc  = 0;
  bit m_err = 1'b0;

  always @(negedge clk) begin
    logic [7:0] got_v;
    logic [7:0] exp_v;
    bit lu;
    bit fz;
    bit br;
    got_v = {hz.PC_Write, hz.IF_ID_Write, hz.ID_EX_Write,
             hz.EX_MEM_Write, hz.IF_ID_Flush, hz.ID_EX_Bubble,
             hz.MEM_WB_Bubble, hz.stall};
    if (!rst_n) begin
      m_run = 0;
      m_sc  = 0;
      m_fc  = 0;
      m_err = 1'b0;
      chk("rst_ctl", 32'(got_v), 32'h0F);
      chk("rst_err", 32'(hz.MEM_Err), 0);
      chk("rst_sc", 32'(hz.StallCycles), 0);
      chk("rst_fc", 32'(hz.FlushCount), 0);
    end else begin
      lu = hz.ID_EX_MemR && (hz.ID_EX_RegRd != 0)
        && ((hz.ID_EX_RegRd == hz.IF_ID_RegRs1 && hz.IF_ID_UsesRs1)
         || (hz.ID_EX_RegRd == hz.IF_ID_RegRs2 && hz.IF_ID_UsesRs2));
      fz = hz.MEM_Req && !hz.MEM_Ready;
      br = hz.EX_BranchTaken;
      if (m_err || fz) exp_v = 8'b0000_0011;
      else if (br)     exp_v = 8'b1111_1100;
      else if (lu)     exp_v = 8'b0011_0101;
      else             exp_v = 8'b1111_0000;
      chk("ctl", 32'(got_v), 32'(exp_v));
      chk("mem_err", 32'(hz.MEM_Err), 32'(m_err));
      chk("stall_cnt", 32'(hz.StallCycles), 32'(m_sc));
      chk("flush_cnt", 32'(hz.FlushCount), 32'(m_fc));
      if (!m_err) begin
        if (exp_v[0] && m_sc < SMAX) m_sc++;
        if (!fz && br && m_fc < SMAX) m_fc++;
        if (fz) begin
          m_run++;
          if (TMO != 0 && m_run == TMO + 1) m_err = 1'b1;
        end else begin
          m_run = 0;
        end
      end
    end
  end

  initial begin
    idle();
    step();
    chk("r_pc", 32'(hz.PC_Write), 0);
    chk("r_flush", 32'(hz.IF_ID_Flush), 1);
    chk("r_stall", 32'(hz.stall), 1);
    step();
    rst_n = 1'b1;
    #1 chk("sc0", 32'(hz.StallCycles), 0);
    step();

    // load-use
    set_lu();
    #1;
    chk("lu_pc", 32'(hz.PC_Write), 0);
    chk("lu_ifid", 32'(hz.IF_ID_Write), 0);
    chk("lu_bub", 32'(hz.ID_EX_Bubble), 1);
    chk("lu_stall", 32'(hz.stall), 1);
    step();
    idle();
    #1 chk("lu_sc", 32'(hz.StallCycles), 1);

    // false hazards
    hz.ID_EX_MemR    = 1'b1;
    hz.IF_ID_UsesRs1 = 1'b1;
    #1 chk("x0_stall", 32'(hz.stall), 0);
    step();
    hz.ID_EX_MemR    = 1'b1;
    hz.ID_EX_RegRd   = 5'd5;
    hz.IF_ID_RegRs1  = 5'd3;
    hz.IF_ID_UsesRs1 = 1'b1;
    hz.IF_ID_RegRs2  = 5'd5;
    hz.IF_ID_UsesRs2 = 1'b0;
    #1 chk("rs2u_stall", 32'(hz.stall), 0);
    step();
    idle();

    // branch + load-use
    set_lu();
    hz.EX_BranchTaken = 1'b1;
    #1;
    chk("bl_flush", 32'(hz.IF_ID_Flush), 1);
    chk("bl_bub", 32'(hz.ID_EX_Bubble), 1);
    chk("bl_pc", 32'(hz.PC_Write), 1);
    chk("bl_stall", 32'(hz.stall), 0);
    step();
    idle();
    #1 chk("bl_fc", 32'(hz.FlushCount), 1);

    // memory wait with held branch
    pulse_rst();
    hz.MEM_Req        = 1'b1;
    hz.EX_BranchTaken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mw_pc", 32'(hz.PC_Write), 0);
      chk("mw_wb", 32'(hz.MEM_WB_Bubble), 1);
      chk("mw_flush", 32'(hz.IF_ID_Flush), 0);
      step();
    end
    hz.MEM_Ready = 1'b1;
    #1;
    chk("mw_br_flush", 32'(hz.IF_ID_Flush), 1);
    chk("mw_br_stall", 32'(hz.stall), 0);
    step();
    idle();
    #1;
    chk("mw_sc", 32'(hz.StallCycles), 3);
    chk("mw_fc", 32'(hz.FlushCount), 1);

    // watchdog
    hz.MEM_Req = 1'b1;
    repeat (4) step();
    chk("wd_err4", 32'(hz.MEM_Err), 0);
    step();
    chk("wd_err5", 32'(hz.MEM_Err), 1);
    hz.MEM_Req = 1'b0;
    #1;
    chk("wd_pc", 32'(hz.PC_Write), 0);
    chk("wd_stall", 32'(hz.stall), 1);
    chk("wd_sc", 32'(hz.StallCycles), 8);
    step();
    chk("wd_hold", 32'(hz.MEM_Err), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("wd_rst_err", 32'(hz.MEM_Err), 0);
    chk("wd_rst_sc", 32'(hz.StallCycles), 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("wd_run_stall", 32'(hz.stall), 0);
    chk("wd_run_pc", 32'(hz.PC_Write), 1);

    // saturation
    for (int k = 0; k < 20; k++) begin
      set_lu();
      step();
      idle();
      step();
    end
    chk("sat_sc", 32'(hz.StallCycles), 15);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 249) begin
        idle();
        pulse_rst();
      end
      hz.IF_ID_RegRs1   = 5'($urandom_range(0, 3));
      hz.IF_ID_RegRs2   = 5'($urandom_range(0, 3));
      hz.ID_EX_RegRd    = 5'($urandom_range(0, 3));
      hz.IF_ID_UsesRs1  = 1'($urandom % 2);
      hz.IF_ID_UsesRs2  = 1'($urandom % 2);
      hz.ID_EX_MemR     = 1'($urandom % 2);
      hz.EX_BranchTaken = ($urandom % 6) == 0;
      hz.MEM_Req        = 1'($urandom % 2);
      hz.MEM_Ready      = ($urandom % 4) != 0;
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
